// File: rtl/lfsr_decoder.sv
// Recovers the seed and tap of an LFSR-ciphered byte stream from its preamble, then decrypts the payload.
// Latency: a payload byte accepted in cycle n appears on out_valid_o in cycle n+1; one byte per cycle sustained.
// Backpressure: in_ready_o drops while the output register is full and out_ready_i is low; held output stays stable.
module lfsr_decoder #(
    parameter int         W        = 8,
    parameter int         PRE_LEN  = 6,
    parameter logic [7:0] PRE_CHAR = 8'h20
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    input  logic         in_last_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic         out_last_o,
    output logic [3:0]   tap_sel_o,
    output logic         done_o,
    output logic         err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_TRAIN,
        S_DECODE,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    // The nine candidate feedback masks, indexed by tap_sel.
    function automatic logic [6:0] tap_of(input int idx);
        case (idx)
            0:       return 7'h60;
            1:       return 7'h48;
            2:       return 7'h78;
            3:       return 7'h72;
            4:       return 7'h6A;
            5:       return 7'h69;
            6:       return 7'h5C;
            7:       return 7'h7E;
            8:       return 7'h7B;
            default: return 7'h60;
        endcase
    endfunction

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] tap);
        return {s[5:0], ^(s & tap)};
    endfunction

    state_t       state_q;
    logic [6:0]   cand_q [9];
    logic [8:0]   alive_q;
    logic [3:0]   pre_cnt_q;
    logic [3:0]   tap_sel_q;
    logic         out_valid_q;
    logic [W-1:0] out_data_q;
    logic         out_last_q;
    logic         done_q;
    logic         err_q;

    logic         accept_d;
    logic [6:0]   exp_d;
    logic         par_ok_d;
    logic [6:0]   cand_adv_d [9];
    logic [6:0]   seed_adv_d [9];
    logic [8:0]   match_d;
    logic [8:0]   alive_d;
    logic [3:0]   pre_cnt_d;
    logic [3:0]   sel_d;
    logic [6:0]   key_d;

    // Ready depends on state; in DECODE it also passes through out_ready_i. A Start cycle never takes a byte.
    always_comb begin
        in_ready_o = 1'b0;
        case (state_q)
            S_SEED, S_TRAIN: in_ready_o = 1'b1;
            S_DECODE:        in_ready_o = !out_valid_q || out_ready_i;
            default:         in_ready_o = 1'b0;
        endcase
        if (start_i) in_ready_o = 1'b0;
    end

    assign accept_d  = in_valid_i && in_ready_o;
    assign exp_d     = in_data_i[6:0] ^ PRE_CHAR[6:0];
    assign par_ok_d  = ~(^in_data_i);
    assign alive_d   = alive_q & match_d;
    assign pre_cnt_d = pre_cnt_q + 4'd1;

    // Per-candidate next state, seeded next state and preamble match (bad parity kills every candidate).
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            cand_adv_d[i] = lfsr_step(cand_q[i], tap_of(i));
            seed_adv_d[i] = lfsr_step(exp_d, tap_of(i));
            match_d[i]    = par_ok_d && (cand_q[i] == exp_d);
        end
    end

    // Lowest surviving candidate wins when several taps agree over the preamble.
    always_comb begin
        sel_d = '0;
        for (int i = 8; i >= 0; i--) begin
            if (alive_d[i]) sel_d = 4'(i);
        end
    end

    // Keystream byte of the chosen tap for the current payload position.
    always_comb begin
        key_d = cand_q[0];
        for (int i = 0; i < 9; i++) begin
            if (tap_sel_q == 4'(i)) key_d = cand_q[i];
        end
    end

    // Frame FSM with all outputs registered; Start aborts from any state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < 9; i++) cand_q[i] <= '0;
            alive_q     <= '0;
            pre_cnt_q   <= '0;
            tap_sel_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else if (start_i) begin
            state_q     <= S_SEED;
            alive_q     <= '0;
            pre_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_SEED: begin
                    if (accept_d) begin
                        if (in_last_i) begin
                            state_q <= S_ERR;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            cand_q    <= seed_adv_d;
                            alive_q   <= 9'h1FF;
                            pre_cnt_q <= 4'd1;
                            state_q   <= S_TRAIN;
                        end
                    end
                end
                S_TRAIN: begin
                    if (accept_d) begin
                        if (in_last_i) begin
                            state_q <= S_ERR;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            cand_q    <= cand_adv_d;
                            alive_q   <= alive_d;
                            pre_cnt_q <= pre_cnt_d;
                            if (pre_cnt_d == 4'(PRE_LEN)) begin
                                if (alive_d == '0) begin
                                    state_q <= S_ERR;
                                    done_q  <= 1'b1;
                                    err_q   <= 1'b1;
                                end else begin
                                    tap_sel_q <= sel_d;
                                    state_q   <= S_DECODE;
                                end
                            end
                        end
                    end
                end
                S_DECODE: begin
                    if (accept_d) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= {^in_data_i, in_data_i[6:0] ^ key_d};
                        out_last_q  <= in_last_i;
                        cand_q      <= cand_adv_d;
                        if (in_last_i) state_q <= S_DRAIN;
                    end else if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (!out_valid_q || out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign tap_sel_o   = tap_sel_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_lfsr_decoder.sv
// Self-checking bench for lfsr_decoder: encrypts frames with a reference model and scoreboards the output.
// Expected bytes are queued as payload is driven and popped when the DUT hands a byte downstream.
// Outputs are sampled on the falling edge; inputs change 1ns after the rising edge.
module tb_lfsr_decoder;

    localparam int PRE_LEN = 6;

    logic       clk_i       = 1'b0;
    logic       rst_i       = 1'b1;
    logic       start_i     = 1'b0;
    logic       in_valid_i  = 1'b0;
    logic [7:0] in_data_i   = 8'h00;
    logic       in_last_i   = 1'b0;
    logic       out_ready_i = 1'b1;
    logic       in_ready_o;
    logic       out_valid_o;
    logic [7:0] out_data_o;
    logic       out_last_o;
    logic [3:0] tap_sel_o;
    logic       done_o;
    logic       err_o;

    lfsr_decoder #(.W(8), .PRE_LEN(PRE_LEN), .PRE_CHAR(8'h20)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .tap_sel_o   (tap_sel_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         out_cnt  = 0;
    int         par_cnt  = 0;
    logic [8:0] exp_q [$];
    logic [6:0] pl [$];
    logic       held_vld = 1'b0;
    logic [7:0] held_dat = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] tap_of(input int idx);
        logic [6:0] t [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
        return t[idx];
    endfunction

    function automatic logic [6:0] step7(input logic [6:0] s, input int idx);
        return {s[5:0], ^(s & tap_of(idx))};
    endfunction

    // Lowest tap whose keystream agrees with the generating tap over every trained preamble byte.
    function automatic int exp_sel(input logic [6:0] seed, input int gen);
        for (int j = 0; j < 9; j++) begin
            logic [6:0] sg = seed;
            logic [6:0] sj = seed;
            bit ok = 1'b1;
            for (int k = 1; k < PRE_LEN; k++) begin
                sg = step7(sg, gen);
                sj = step7(sj, j);
                if (sg != sj) ok = 1'b0;
            end
            if (ok) return j;
        end
        return gen;
    endfunction

    // Output monitor: scoreboard pop on handshake, stability check while stalled.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (out_valid_o && !out_ready_i) begin
                if (held_vld) check("hold_stable", {24'h0, out_data_o}, {24'h0, held_dat});
                held_vld = 1'b1;
                held_dat = out_data_o;
            end else begin
                held_vld = 1'b0;
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("extra_out", {23'h0, out_last_o, out_data_o}, 32'h1FF);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("out_data", {24'h0, out_data_o}, {24'h0, e[7:0]});
                    check("out_last", {31'h0, out_last_o}, {31'h0, e[8]});
                end
                out_cnt++;
                if (out_data_o[7]) par_cnt++;
            end
        end
    end

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int cnt = 0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = last;
        do begin
            @(negedge clk_i);
            cnt++;
        end while (!in_ready_o && cnt < 300);
        check("in_accept", {31'h0, in_ready_o}, 32'h1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_preamble(input logic [6:0] seed, input int gen);
        logic [6:0] s = seed;
        logic [6:0] c7;
        for (int k = 0; k < PRE_LEN; k++) begin
            c7 = 7'h20 ^ s;
            send_byte({^c7, c7}, 1'b0);
            s = step7(s, gen);
        end
    endtask

    // Encrypts the global payload with (seed, gen); optionally queues model expectations.
    task automatic send_frame(input logic [6:0] seed, input int gen, input int flip_idx,
                              input bit push, output int sel);
        logic [6:0] s;
        logic [6:0] ks;
        logic [6:0] c7;
        logic [7:0] c;
        logic       last;
        sel = exp_sel(seed, gen);
        send_preamble(seed, gen);
        s  = seed;
        ks = seed;
        for (int k = 0; k < PRE_LEN; k++) begin
            s  = step7(s, gen);
            ks = step7(ks, sel);
        end
        for (int m = 0; m < pl.size(); m++) begin
            c7 = pl[m] ^ s;
            c  = {^c7, c7};
            if (m == flip_idx) c[7] = ~c[7];
            last = (m == pl.size() - 1);
            if (push) exp_q.push_back({last, ^c, c7 ^ ks});
            send_byte(c, last);
            s  = step7(s, gen);
            ks = step7(ks, sel);
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic fill_pl(input int n);
        pl.delete();
        repeat (n) pl.push_back(7'($urandom_range(0, 127)));
    endtask

    task automatic wait_done(input string tag);
        int cnt = 0;
        while (!done_o && cnt < 500) begin
            @(negedge clk_i);
            cnt++;
        end
        check(tag, {31'h0, done_o}, 32'h1);
        check("sb_empty", exp_q.size(), 32'h0);
    endtask

    task automatic stall_out(input int base);
        int cnt = 0;
        while (out_cnt < base + 8 && cnt < 500) begin
            @(negedge clk_i);
            cnt++;
        end
        @(posedge clk_i);
        #1 out_ready_i = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            check("stall_in_ready", {31'h0, in_ready_o}, 32'h0);
            check("stall_out_valid", {31'h0, out_valid_o}, 32'h1);
        end
        @(posedge clk_i);
        #1 out_ready_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sel;
        int base;

        // Reset values while reset is held, then IDLE after release.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_in_ready", {31'h0, in_ready_o}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid_o}, 32'h0);
        check("rst_out_data", {24'h0, out_data_o}, 32'h0);
        check("rst_out_last", {31'h0, out_last_o}, 32'h0);
        check("rst_tap_sel", {28'h0, tap_sel_o}, 32'h0);
        check("rst_done", {31'h0, done_o}, 32'h0);
        check("rst_err", {31'h0, err_o}, 32'h0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_in_ready", {31'h0, in_ready_o}, 32'h0);
        @(posedge clk_i);
        #1;

        // "Hi" with tap 0x60 and seed 0x01, expected values written out by hand.
        pulse_start();
        pl.delete();
        pl.push_back(7'h48);
        pl.push_back(7'h69);
        exp_q.push_back({1'b0, 8'h48});
        exp_q.push_back({1'b1, 8'h69});
        base = out_cnt;
        send_frame(7'h01, 0, -1, 1'b0, sel);
        wait_done("hi_done");
        check("hi_tap_sel", {28'h0, tap_sel_o}, 32'h0);
        check("hi_err", {31'h0, err_o}, 32'h0);
        check("hi_count", out_cnt - base, 32'd2);

        // All nine taps, seed 0x5A, 32 random payload bytes; tap 4 also gets a 5-cycle output stall.
        for (int t = 0; t < 9; t++) begin
            pulse_start();
            par_cnt = 0;
            fill_pl(32);
            if (t == 4) begin
                base = out_cnt;
                fork
                    send_frame(7'h5A, t, -1, 1'b1, sel);
                    stall_out(base);
                join
            end else begin
                send_frame(7'h5A, t, -1, 1'b1, sel);
            end
            wait_done("sweep_done");
            check("sweep_tap_sel", {28'h0, tap_sel_o}, sel);
            check("sweep_err", {31'h0, err_o}, 32'h0);
            check("sweep_parity", par_cnt, 32'h0);
        end

        // Bad parity on payload byte 3 flags that byte only.
        pulse_start();
        par_cnt = 0;
        fill_pl(10);
        send_frame(7'h33, 2, 3, 1'b1, sel);
        wait_done("flip_done");
        check("flip_parity_count", par_cnt, 32'h1);

        // Preamble matching no tap ends in ERR with nothing output.
        pulse_start();
        base = out_cnt;
        send_byte(8'h55, 1'b0);
        repeat (PRE_LEN - 1) send_byte(8'h00, 1'b0);
        in_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("nomatch_err", {31'h0, err_o}, 32'h1);
        check("nomatch_done", {31'h0, done_o}, 32'h1);
        check("nomatch_no_out", out_cnt - base, 32'h0);
        @(posedge clk_i);
        #1;

        // Start during DECODE discards the pending byte; the next frame decodes cleanly.
        pulse_start();
        out_ready_i = 1'b0;
        send_preamble(7'h11, 3);
        send_byte(8'h3C, 1'b0);
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("pending_valid", {31'h0, out_valid_o}, 32'h1);
        @(posedge clk_i);
        #1;
        pulse_start();
        @(negedge clk_i);
        check("abort_out_valid", {31'h0, out_valid_o}, 32'h0);
        check("abort_done", {31'h0, done_o}, 32'h0);
        @(posedge clk_i);
        #1 out_ready_i = 1'b1;
        fill_pl(12);
        base = out_cnt;
        send_frame(7'h2B, 5, -1, 1'b1, sel);
        wait_done("restart_done");
        check("restart_tap_sel", {28'h0, tap_sel_o}, sel);
        check("restart_count", out_cnt - base, 32'd12);

        // Reset asserted mid-TRAIN, between clock edges, clears every output at once.
        pulse_start();
        send_byte(8'h64, 1'b0);
        send_byte(8'h48, 1'b0);
        send_byte(8'h50, 1'b0);
        in_valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        check("arst_in_ready", {31'h0, in_ready_o}, 32'h0);
        check("arst_out_valid", {31'h0, out_valid_o}, 32'h0);
        check("arst_out_data", {24'h0, out_data_o}, 32'h0);
        check("arst_out_last", {31'h0, out_last_o}, 32'h0);
        check("arst_tap_sel", {28'h0, tap_sel_o}, 32'h0);
        check("arst_done", {31'h0, done_o}, 32'h0);
        check("arst_err", {31'h0, err_o}, 32'h0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (2) @(posedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
